move_undo_stack: RTL and testbench
==================================

# move_undo_stack

Move journal that records every move the cube state block applies and, on request, pops the most recent move and emits its inverse. The inverse uses the same face/rotation encoding, so it can be fed straight back to the move-apply logic to restore the previous cube state. It sits beside the move-apply datapath: the move issuer drives both this block and the move-apply logic, and the move-apply logic also takes its undo moves from this block.

## Interface
- DEPTH, 64, journal entries; must be a power of two, at least 2
- PTR_W, 6, log2(DEPTH)
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- moveValid  in  1  a forward move is applied this cycle; record it
- moveFace  in  6  face code: 0=U, 1=L, 2=F, 3=R, 4=B, 5=D
- moveRotation  in  2  value r means r+1 clockwise quarter turns; r=3 is identity
- undoReq  in  1  request to pop and emit the inverse of the newest entry
- clearReq  in  1  discard the whole journal
- outValid  out  1  one-cycle pulse; outFace/outRotation are valid this cycle
- outFace  out  6  face of the inverse move
- outRotation  out  2  rotation code of the inverse move
- busy  out  1  an undo is in progress (state is not IDLE)
- count  out  PTR_W+1  number of stored entries, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- errFlag  out  1  sticky; set on a dropped or invalid record

## Operation
- Storage is a circular buffer of DEPTH entries, 8 bits each ({face, rotation}). It has a write pointer `head` (PTR_W bits, next free slot) and `count`.
- Record, accepted only in IDLE when moveValid=1 and moveFace<=5:
  - mem[head] <= {moveFace, moveRotation}
  - head <= head+1 (mod DEPTH)
  - count <= min(count+1, DEPTH)
  - When full, the oldest entry is overwritten and count stays at DEPTH.
- Invalid record: moveValid=1 with moveFace>5 is not stored and sets errFlag.
- Record while busy: moveValid=1 when not in IDLE is dropped and sets errFlag.
- Inverse rotation: outRotation = (2 - r) mod 4, i.e. 0->2, 1->1, 2->0, 3->3. outFace = stored face.
- Moves emitted on outValid are never recorded. The issuer must not echo them back on moveValid.
- FSM states are IDLE, READ and EMIT:
  - IDLE -> READ on undoReq=1, count>0, moveValid=0 and clearReq=0. On this transition head <= head-1 (mod DEPTH) and count <= count-1.
  - READ: synchronous memory read of mem[head]; go to EMIT.
  - EMIT: outValid=1, outputs driven from registers; go to IDLE.
  - In IDLE, undoReq with count==0 is ignored. It produces no pulse and does not set errFlag.
- Priority within a cycle: reset > clearReq > record > undoReq.
  - When moveValid and undoReq are both high in IDLE, only the record happens; the undoReq is discarded, not queued.
- clearReq, in any state:
  - head=0, count=0, errFlag=0, state=IDLE.
  - An undo in flight is aborted; no outValid.
- undoReq while busy is ignored.

## Timing
- Reset values: outValid=0, outFace=0, outRotation=0, busy=0, count=0, empty=1, full=0, errFlag=0, head=0, state=IDLE. Memory contents need no reset.
- Reset asserted mid-undo aborts it. No outValid is produced in the cycle after reset or in any later cycle for that undo.
- Record latency: count, empty, full and errFlag update at the edge that samples moveValid and are visible the next cycle.
- Undo latency, with undoReq sampled at edge T:
  - busy=1 and the decremented count are visible in cycles T+1 and T+2.
  - outValid=1 for exactly cycle T+2 only.
  - busy=0 from T+3, and the next undo can be accepted at edge T+3.
- Maximum undo throughput is one inverse move every 3 cycles.
- outFace/outRotation hold their last emitted value when outValid=0.
- empty and full are combinational from count and always consistent with it.

## Test plan
- Record and undo: after reset, record (F,r=0), (R,r=2), (U,r=1), then three undos. Required pulses, in order: (U,1), (R,0), (F,2). count goes 3->0, then empty=1.
- Identity and inverse checks: a model applies each recorded move, then each emitted inverse, using the same move semantics. After every undo the cube state must equal the state before the matching move. Cover all 6 faces × 4 rotations.
- Wrap and overflow: with DEPTH=4, record 6 moves M0..M5. Required: count=4, full=1, errFlag=0. Undoing 4 times yields inv(M5), inv(M4), inv(M3), inv(M2). A 5th undo gives no pulse.
- Conflicts:
  - moveValid and undoReq in the same IDLE cycle: only the record happens, count increments, no pulse.
  - moveValid during busy: dropped, errFlag=1.
  - moveFace=6: not stored, errFlag=1.
- Empty undo: undoReq at count=0 gives no outValid for 5 cycles and errFlag stays 0.
- Abort: assert undoReq, then clearReq at T+1. Required: no outValid, count=0, errFlag=0. Repeat with reset instead of clearReq, with the same result.

Source files
------------

// File: rtl/move_undo_stack.sv
// Move journal: records applied cube moves in a circular buffer and pops the newest as its inverse.
// Undo latency 2 cycles (pulse at T+2), one undo per 3 cycles; no backpressure, conflicting records set errFlag.
module move_undo_stack #(
   parameter int DEPTH = 64,
   parameter int PTR_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             moveValid,
   input  logic [5:0]       moveFace,
   input  logic [1:0]       moveRotation,
   input  logic             undoReq,
   input  logic             clearReq,
   output logic             outValid,
   output logic [5:0]       outFace,
   output logic [1:0]       outRotation,
   output logic             busy,
   output logic [PTR_W:0]   count,
   output logic             empty,
   output logic             full,
   output logic             errFlag
);

   typedef enum logic [1:0] {IDLE, READ, EMIT} state_t;

   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [PTR_W-1:0] head;
   logic [7:0]       mem [DEPTH];
   logic             rec_ok;
   logic             rec_bad;
   logic             undo_go;

   always_comb begin
      rec_ok    = (state == IDLE) && moveValid && (moveFace <= 6'd5) && !clearReq;
      rec_bad   = moveValid && ((state != IDLE) || (moveFace > 6'd5));
      undo_go   = (state == IDLE) && undoReq && !moveValid && !clearReq && (count != '0);
      state_nxt = state;
      unique case (state)
         IDLE:    if (undo_go) state_nxt = READ;
         READ:    state_nxt = EMIT;
         EMIT:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clearReq) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head        <= '0;
         count       <= '0;
         errFlag     <= 1'b0;
         outFace     <= '0;
         outRotation <= '0;
      end else if (clearReq) begin
         // Outputs keep the last emitted move; an aborted undo never reaches them.
         head    <= '0;
         count   <= '0;
         errFlag <= 1'b0;
      end else begin
         if (rec_bad) errFlag <= 1'b1;
         if (rec_ok) begin
            head <= head + PTR_ONE;
            if (count != CNT_MAX) count <= count + CNT_ONE;
         end else if (undo_go) begin
            head  <= head - PTR_ONE;
            count <= count - CNT_ONE;
         end
         // head already points at the newest entry; inverse of r is (2 - r) mod 4.
         if (state == READ) begin
            outFace     <= mem[head][7:2];
            outRotation <= 2'd2 - mem[head][1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && rec_ok) mem[head] <= {moveFace, moveRotation};
   end

   assign outValid = (state == EMIT);
   assign busy     = (state != IDLE);
   assign empty    = (count == '0);
   assign full     = (count == CNT_MAX);

endmodule

// File: tb/tb_move_undo_stack.sv
// Bench for move_undo_stack at DEPTH=4: directed scenarios plus random traffic against a queue-based journal model.
module tb_move_undo_stack;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             moveValid;
   logic [5:0]       moveFace;
   logic [1:0]       moveRotation;
   logic             undoReq;
   logic             clearReq;
   logic             outValid;
   logic [5:0]       outFace;
   logic [1:0]       outRotation;
   logic             busy;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic             errFlag;

   always #5 clk = ~clk;

   move_undo_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .reset(reset), .moveValid(moveValid), .moveFace(moveFace),
      .moveRotation(moveRotation), .undoReq(undoReq), .clearReq(clearReq),
      .outValid(outValid), .outFace(outFace), .outRotation(outRotation), .busy(busy),
      .count(count), .empty(empty), .full(full), .errFlag(errFlag)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Model: journal as a queue of {face,rot}; undo tracked as cycles since acceptance.
   logic [7:0] jq [$];
   logic [7:0] plog [$];
   int         m_phase = 0;
   logic       m_err = 1'b0;
   logic [7:0] m_pend = '0;
   logic [7:0] m_last = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Inverse by quarter-turn arithmetic: code r means r+1 turns; undo turns = -(r+1) mod 4.
   function automatic logic [7:0] inv_move(input logic [7:0] m);
      int q, iq, code;
      q    = (int'(m[1:0]) + 1) % 4;
      iq   = (4 - q) % 4;
      code = (iq + 3) % 4;
      return {m[7:2], 2'(code)};
   endfunction

   task automatic model_edge(input logic mv, input logic [5:0] f, input logic [1:0] r,
                             input logic u, input logic c, input logic rs);
      if (rs) begin
         jq.delete(); m_phase = 0; m_err = 1'b0; m_last = '0;
      end else if (c) begin
         jq.delete(); m_phase = 0; m_err = 1'b0;
      end else if (m_phase == 0) begin
         if (mv) begin
            if (f <= 6'd5) begin
               jq.push_back({f, r});
               if (jq.size() > DEPTH) jq.delete(0);
            end else m_err = 1'b1;
         end else if (u && jq.size() > 0) begin
            m_pend = jq.pop_back();
            m_phase = 1;
         end
      end else begin
         if (mv) m_err = 1'b1;
         if (m_phase == 1) begin
            m_last = inv_move(m_pend);
            m_phase = 2;
         end else m_phase = 0;
      end
   endtask

   task automatic check_all();
      chk("outValid", 32'(outValid), 32'(m_phase == 2));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("count", 32'(count), 32'(jq.size()));
      chk("empty", 32'(empty), 32'(jq.size() == 0));
      chk("full", 32'(full), 32'(jq.size() == DEPTH));
      chk("errFlag", 32'(errFlag), 32'(m_err));
      chk("outFace", 32'(outFace), 32'(m_last[7:2]));
      chk("outRotation", 32'(outRotation), 32'(m_last[1:0]));
      if (outValid) plog.push_back({outFace, outRotation});
   endtask

   task automatic cyc(input logic mv, input logic [5:0] f, input logic [1:0] r,
                      input logic u, input logic c, input logic rs);
      moveValid = mv; moveFace = f; moveRotation = r;
      undoReq = u; clearReq = c; reset = rs;
      @(posedge clk);
      model_edge(mv, f, r, u, c, rs);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rec(input logic [5:0] f, input logic [1:0] r);
      cyc(1'b1, f, r, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic undo();
      cyc(1'b0, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      idle(2);
   endtask

   task automatic do_reset();
      cyc(1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [7:0] exp1 [3];
      logic [7:0] mv_list [6];
      logic [7:0] p;
      int         cube [6];
      int         bad;
      logic       r_mv, r_u, r_c, r_rs;
      logic [5:0] r_f;
      logic [1:0] r_r;

      // Reset state
      do_reset();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_count", 32'(count), 32'd0);

      // Record three moves, undo three times
      plog.delete();
      rec(6'd2, 2'd0); rec(6'd3, 2'd2); rec(6'd0, 2'd1);
      undo(); undo(); undo();
      exp1[0] = {6'd0, 2'd1}; exp1[1] = {6'd3, 2'd0}; exp1[2] = {6'd2, 2'd2};
      chk("t1_npulse", 32'(plog.size()), 32'd3);
      for (int i = 0; i < plog.size() && i < 3; i++) chk("t1_pulse", 32'(plog[i]), 32'(exp1[i]));
      chk("t1_empty", 32'(empty), 32'd1);

      // Wrap and overflow
      do_reset();
      for (int i = 0; i < 6; i++) begin
         mv_list[i] = {6'(i), 2'(i % 4)};
         rec(mv_list[i][7:2], mv_list[i][1:0]);
      end
      chk("t2_count", 32'(count), 32'd4);
      chk("t2_full", 32'(full), 32'd1);
      chk("t2_err", 32'(errFlag), 32'd0);
      plog.delete();
      for (int i = 0; i < 5; i++) undo();
      chk("t2_npulse", 32'(plog.size()), 32'd4);
      for (int i = 0; i < plog.size() && i < 4; i++)
         chk("t2_pulse", 32'(plog[i]), 32'(inv_move(mv_list[5 - i])));

      // Conflicts
      do_reset();
      plog.delete();
      cyc(1'b1, 6'd1, 2'd3, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk("t3_both_count", 32'(count), 32'd1);
      chk("t3_both_npulse", 32'(plog.size()), 32'd0);
      cyc(1'b0, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 6'd4, 2'd1, 1'b0, 1'b0, 1'b0);
      idle(2);
      chk("t3_busy_err", 32'(errFlag), 32'd1);
      chk("t3_busy_count", 32'(count), 32'd0);
      cyc(1'b0, 6'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      rec(6'd6, 2'd0);
      chk("t3_face6_err", 32'(errFlag), 32'd1);
      chk("t3_face6_count", 32'(count), 32'd0);

      // Empty undo
      do_reset();
      plog.delete();
      cyc(1'b0, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      idle(5);
      chk("t4_npulse", 32'(plog.size()), 32'd0);
      chk("t4_err", 32'(errFlag), 32'd0);

      // Abort by clear, then by reset
      rec(6'd5, 2'd2); rec(6'd1, 2'd1);
      plog.delete();
      cyc(1'b0, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 6'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      idle(4);
      chk("t5_clr_npulse", 32'(plog.size()), 32'd0);
      chk("t5_clr_count", 32'(count), 32'd0);
      rec(6'd5, 2'd2); rec(6'd1, 2'd1);
      cyc(1'b0, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      idle(4);
      chk("t5_rst_npulse", 32'(plog.size()), 32'd0);
      chk("t5_rst_count", 32'(count), 32'd0);
      chk("t5_rst_err", 32'(errFlag), 32'd0);

      // Every face x rotation: move then its emitted inverse must restore the cube
      do_reset();
      for (int i = 0; i < 6; i++) cube[i] = 0;
      for (int f = 0; f < 6; f++) begin
         for (int r = 0; r < 4; r++) begin
            plog.delete();
            rec(6'(f), 2'(r));
            cube[f] = cube[f] + r + 1;
            undo();
            chk("cube_npulse", 32'(plog.size()), 32'd1);
            if (plog.size() > 0) begin
               p = plog[0];
               if (p[7:2] < 6'd6) cube[p[7:2]] = cube[p[7:2]] + int'(p[1:0]) + 1;
               else cube[0] = cube[0] + 1;
            end
            bad = 0;
            for (int i = 0; i < 6; i++) if (cube[i] % 4 != 0) bad++;
            chk($sformatf("cube_f%0d_r%0d", f, r), 32'(bad), 32'd0);
         end
      end

      // Random traffic
      for (int i = 0; i < 2500; i++) begin
         r_mv = ($urandom_range(0, 99) < 35);
         r_u  = ($urandom_range(0, 99) < 35);
         r_c  = ($urandom_range(0, 99) < 3);
         r_rs = ($urandom_range(0, 199) < 2);
         r_f  = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(6, 63)) : 6'($urandom_range(0, 5));
         r_r  = 2'($urandom_range(0, 3));
         cyc(r_mv, r_f, r_r, r_u, r_c, r_rs);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
